// File: rtl/cnt_match_timer.sv
// cnt_match_timer: match timer fed by a free-running counter.
// An accepted start captures target = count + period. When the counter
// equals the target, the block raises a one-cycle fire pulse one cycle
// later and sets a sticky interrupt. It then either disarms (one-shot)
// or advances the target by the period (periodic). It also tracks
// overruns and keeps a saturating count of events since the last arm.
module cnt_match_timer #(
   parameter int W       = 16,
   parameter int NFIRE_W = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [W-1:0]       i_cnt,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic [W-1:0]       i_period,
   input  logic               i_mode,
   input  logic               i_ack,
   output logic               o_busy,
   output logic               o_fire,
   output logic               o_irq,
   output logic               o_ovr,
   output logic               o_err,
   output logic [NFIRE_W-1:0] o_nfire
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ARMED = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_nextState;
   logic [W-1:0]         r_target;
   logic [W-1:0]         r_period;
   logic                 r_mode;
   logic                 r_fire;
   logic                 r_irq;
   logic                 r_ovr;
   logic                 r_err;
   logic [NFIRE_W-1:0]   r_nfire;

   logic                 w_match;
   logic                 w_arm;
   logic                 w_reject;

   // A match is pure equality, so the block also fires correctly after
   // the counter wraps or after the upstream counter is reset.
   assign w_match  = (r_state == S_ARMED) && (i_cnt == r_target);
   assign w_arm    = (r_state == S_IDLE) && i_start && (i_period != '0);
   assign w_reject = (r_state == S_IDLE) && i_start && (i_period == '0);

   // State register; reset overrides everything, including an armed timer
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: a match takes priority over stop, so the event still fires
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_arm) begin
               w_nextState = S_ARMED;
            end
         end
         S_ARMED: begin
            if (w_match) begin
               if (!r_mode || i_stop) begin
                  w_nextState = S_IDLE;
               end
            end else if (i_stop) begin
               w_nextState = S_IDLE;
            end
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // Target, period, mode and event count; the count survives a return to idle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_target <= '0;
         r_period <= '0;
         r_mode   <= 1'b0;
         r_nfire  <= '0;
      end else if (w_arm) begin
         r_target <= i_cnt + i_period;
         r_period <= i_period;
         r_mode   <= i_mode;
         r_nfire  <= '0;
      end else if (w_match) begin
         if (r_nfire != '1) begin
            r_nfire <= r_nfire + NFIRE_W'(1);
         end
         if (r_mode) begin
            r_target <= r_target + r_period;
         end
      end
   end

   // Event pulse, reject pulse and sticky flags; an event beats a same-cycle ack
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fire <= 1'b0;
         r_err  <= 1'b0;
         r_irq  <= 1'b0;
         r_ovr  <= 1'b0;
      end else begin
         r_fire <= w_match;
         r_err  <= w_reject;
         if (w_match) begin
            r_irq <= 1'b1;
            if (i_ack) begin
               r_ovr <= 1'b0;
            end else if (r_irq) begin
               r_ovr <= 1'b1;
            end
         end else if (i_ack) begin
            r_irq <= 1'b0;
            r_ovr <= 1'b0;
         end
      end
   end

   // Outputs come straight from registered state
   always_comb begin
      o_busy  = (r_state == S_ARMED);
      o_fire  = r_fire;
      o_irq   = r_irq;
      o_ovr   = r_ovr;
      o_err   = r_err;
      o_nfire = r_nfire;
   end

endmodule

// File: tb/tb_cnt_match_timer.sv
// tb_cnt_match_timer: scenario tests plus a randomized run against a
// behavioural model. Both DUTs get the same inputs. One uses an 8-bit
// fire count and the other a 2-bit fire count, so that saturation is
// exercised.
module tb_cnt_match_timer;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [15:0] i_cnt = 16'd0;
   logic        i_start = 1'b0;
   logic        i_stop = 1'b0;
   logic [15:0] i_period = 16'd0;
   logic        i_mode = 1'b0;
   logic        i_ack = 1'b0;

   logic        aBusy, aFire, aIrq, aOvr, aErr;
   logic [7:0]  aNfire;
   logic        bBusy, bFire, bIrq, bOvr, bErr;
   logic [1:0]  bNfire;

   logic [12:0] outsA;
   logic [6:0]  outsB;
   logic [12:0] expA;
   logic [6:0]  expB;

   int nPass = 0;
   int nTotal = 0;

   assign outsA = {aBusy, aFire, aIrq, aOvr, aErr, aNfire};
   assign outsB = {bBusy, bFire, bIrq, bOvr, bErr, bNfire};

   cnt_match_timer #(.W(16), .NFIRE_W(8)) dutA (
      .i_clk(i_clk), .i_rst(i_rst), .i_cnt(i_cnt), .i_start(i_start),
      .i_stop(i_stop), .i_period(i_period), .i_mode(i_mode), .i_ack(i_ack),
      .o_busy(aBusy), .o_fire(aFire), .o_irq(aIrq), .o_ovr(aOvr),
      .o_err(aErr), .o_nfire(aNfire)
   );

   cnt_match_timer #(.W(16), .NFIRE_W(2)) dutB (
      .i_clk(i_clk), .i_rst(i_rst), .i_cnt(i_cnt), .i_start(i_start),
      .i_stop(i_stop), .i_period(i_period), .i_mode(i_mode), .i_ack(i_ack),
      .o_busy(bBusy), .o_fire(bFire), .o_irq(bIrq), .o_ovr(bOvr),
      .o_err(bErr), .o_nfire(bNfire)
   );

   // Free-running clock
   always #5 i_clk = ~i_clk;

   // Reference model: the armed flag, the target as a plain integer mod 65536,
   // and an unbounded event count that is clamped only when compared.
   bit mArmed = 0;
   int mTarget = 0;
   int mPeriod = 0;
   bit mMode = 0;
   int mEvents = 0;
   bit mFire = 0;
   bit mIrq = 0;
   bit mOvr = 0;
   bit mErr = 0;
   bit mHit = 0;

   // Advance the model on every clock using the inputs present at the edge
   always @(posedge i_clk) begin
      if (i_rst) begin
         mArmed = 0; mTarget = 0; mPeriod = 0; mMode = 0; mEvents = 0;
         mFire = 0; mIrq = 0; mOvr = 0; mErr = 0;
      end else begin
         mHit  = mArmed && (mTarget == int'(i_cnt));
         mFire = mHit;
         mErr  = !mArmed && i_start && (i_period == 16'd0);
         if (mHit) begin
            mOvr = i_ack ? 1'b0 : (mIrq ? 1'b1 : mOvr);
            mIrq = 1;
         end else if (i_ack) begin
            mIrq = 0;
            mOvr = 0;
         end
         if (mArmed) begin
            if (mHit) begin
               mEvents = mEvents + 1;
               if (!mMode || i_stop) mArmed = 0;
               else mTarget = (mTarget + mPeriod) % 65536;
            end else if (i_stop) begin
               mArmed = 0;
            end
         end else if (i_start && i_period != 16'd0) begin
            mTarget = (int'(i_cnt) + int'(i_period)) % 65536;
            mPeriod = int'(i_period);
            mMode   = i_mode;
            mEvents = 0;
            mArmed  = 1;
         end
      end
   end

   function automatic int satCount(input int events, input int maxVal);
      return (events > maxVal) ? maxVal : events;
   endfunction

   // One clock: outputs are stable at return, pulses are cleared and the counter advances
   task automatic tick();
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_stop  = 1'b0;
      i_ack   = 1'b0;
      i_rst   = 1'b0;
      i_cnt   = i_cnt + 16'd1;
   endtask

   task automatic resetDut();
      i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_ack = 1'b0;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_start = 1'b1; i_period = 16'd5; i_cnt = 16'd7;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      i_rst = 1'b0; i_start = 1'b0;
      nTotal++;
      if (outsA !== 13'd0) $display("[TB] FAIL reset_A: got %b want %b", outsA, 13'd0);
      else nPass++;
      nTotal++;
      if (outsB !== 7'd0) $display("[TB] FAIL reset_B: got %b want %b", outsB, 7'd0);
      else nPass++;
   endtask

   task automatic test_one_shot();
      resetDut();
      i_cnt = 16'd100; i_period = 16'd5; i_mode = 1'b0; i_start = 1'b1;
      tick();
      expA = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      nTotal++;
      if (outsA !== expA) $display("[TB] FAIL oneshot_armed: got %b want %b", outsA, expA);
      else nPass++;
      for (int k = 0; k < 4; k++) tick();
      nTotal++;
      if (outsA !== expA) $display("[TB] FAIL oneshot_early: got %b want %b", outsA, expA);
      else nPass++;
      tick();
      expA = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
      nTotal++;
      if (outsA !== expA) $display("[TB] FAIL oneshot_fire: got %b want %b", outsA, expA);
      else nPass++;
      tick();
      expA = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
      nTotal++;
      if (outsA !== expA) $display("[TB] FAIL oneshot_after: got %b want %b", outsA, expA);
      else nPass++;
   endtask

   task automatic test_wrap();
      int fireAt[$];
      int n;
      logic [15:0] sampled;
      resetDut();
      i_cnt = 16'hFFFE; i_period = 16'd4; i_mode = 1'b0; i_start = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) tick();
      expA = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      nTotal++;
      if (outsA !== expA) $display("[TB] FAIL wrap_early: got %b want %b", outsA, expA);
      else nPass++;
      tick();
      expA = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
      nTotal++;
      if (outsA !== expA) $display("[TB] FAIL wrap_fire: got %b want %b", outsA, expA);
      else nPass++;

      i_cnt = 16'hFFFF; i_period = 16'd3; i_mode = 1'b1; i_start = 1'b1; i_ack = 1'b1;
      tick();
      n = 0;
      while (fireAt.size() < 3 && n < 20) begin
         sampled = i_cnt;
         tick();
         if (aFire) fireAt.push_back(int'(sampled));
         n++;
      end
      nTotal++;
      if (fireAt.size() != 3 || fireAt[0] != 2 || fireAt[1] != 5 || fireAt[2] != 8)
         $display("[TB] FAIL periodic_wrap_counts: got %p want '{2, 5, 8}", fireAt);
      else nPass++;
      expA = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3};
      nTotal++;
      if (outsA !== expA) $display("[TB] FAIL periodic_wrap_nfire: got %b want %b", outsA, expA);
      else nPass++;
      i_stop = 1'b1;
      tick();
      expA = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3};
      nTotal++;
      if (outsA !== expA) $display("[TB] FAIL periodic_stop: got %b want %b", outsA, expA);
      else nPass++;
   endtask

   task automatic test_interrupt();
      resetDut();
      i_cnt = 16'd10; i_period = 16'd2; i_mode = 1'b1; i_start = 1'b1;
      tick();
      tick(); tick();
      expA = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
      nTotal++;
      if (outsA !== expA) $display("[TB] FAIL irq_first: got %b want %b", outsA, expA);
      else nPass++;
      tick(); tick();
      expA = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2};
      nTotal++;
      if (outsA !== expA) $display("[TB] FAIL irq_overrun: got %b want %b", outsA, expA);
      else nPass++;
      i_ack = 1'b1;
      tick();
      expA = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
      nTotal++;
      if (outsA !== expA) $display("[TB] FAIL irq_ack_clear: got %b want %b", outsA, expA);
      else nPass++;
      tick();
      tick();
      i_ack = 1'b1;
      tick();
      expA = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4};
      nTotal++;
      if (outsA !== expA) $display("[TB] FAIL irq_ack_with_fire: got %b want %b", outsA, expA);
      else nPass++;
      i_stop = 1'b1;
      tick();
   endtask

   task automatic test_reject_abort();
      int fires;
      int fireAt;
      int n;
      resetDut();
      i_cnt = 16'd40; i_period = 16'd0; i_mode = 1'b0; i_start = 1'b1;
      tick();
      expA = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
      nTotal++;
      if (outsA !== expA) $display("[TB] FAIL reject_err: got %b want %b", outsA, expA);
      else nPass++;
      tick();
      nTotal++;
      if (outsA !== 13'd0) $display("[TB] FAIL reject_pulse_end: got %b want %b", outsA, 13'd0);
      else nPass++;

      i_cnt = 16'd50; i_period = 16'd3; i_mode = 1'b1; i_start = 1'b1;
      tick();
      tick(); tick();
      i_stop = 1'b1;
      tick();
      expA = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
      nTotal++;
      if (outsA !== expA) $display("[TB] FAIL stop_in_match: got %b want %b", outsA, expA);
      else nPass++;
      fires = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (aFire || aBusy) fires++;
      end
      nTotal++;
      if (fires != 0) $display("[TB] FAIL stop_then_idle: got %0d active cycles want 0", fires);
      else nPass++;

      i_cnt = 16'd200; i_period = 16'd10; i_mode = 1'b0; i_start = 1'b1;
      tick();
      tick(); tick();
      i_start = 1'b1; i_period = 16'd2;
      tick();
      i_start = 1'b1; i_period = 16'd0;
      tick();
      expA = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      nTotal++;
      if (outsA !== expA) $display("[TB] FAIL start_while_armed_flags: got %b want %b", outsA, expA);
      else nPass++;
      fireAt = -1;
      n = 0;
      while (fireAt < 0 && n < 20) begin
         fireAt = int'(i_cnt);
         tick();
         if (!aFire) fireAt = -1;
         n++;
      end
      nTotal++;
      if (fireAt != 210) $display("[TB] FAIL start_while_armed_target: got fire at count %0d want 210", fireAt);
      else nPass++;
   endtask

   task automatic test_saturation();
      resetDut();
      i_cnt = 16'd0; i_period = 16'd1; i_mode = 1'b1; i_start = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) tick();
      expB = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3};
      nTotal++;
      if (outsB !== expB) $display("[TB] FAIL saturate_B: got %b want %b", outsB, expB);
      else nPass++;
      nTotal++;
      if (aNfire !== 8'd5) $display("[TB] FAIL saturate_A_count: got %0d want 5", aNfire);
      else nPass++;
      i_rst = 1'b1;
      tick();
      nTotal++;
      if (outsA !== 13'd0 || outsB !== 7'd0)
         $display("[TB] FAIL midrun_reset: got A %b B %b want all zero", outsA, outsB);
      else nPass++;
   endtask

   task automatic test_random();
      int sel;
      int shown = 0;
      resetDut();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         i_rst   = ($urandom_range(0, 199) == 0);
         i_start = ($urandom_range(0, 9) == 0);
         i_stop  = ($urandom_range(0, 29) == 0);
         i_ack   = ($urandom_range(0, 7) == 0);
         i_mode  = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 15);
         if (sel == 0) i_period = 16'd0;
         else if (sel == 1) i_period = 16'($urandom);
         else i_period = 16'($urandom_range(1, 12));
         sel = $urandom_range(0, 99);
         if (sel < 80) i_cnt = i_cnt + 16'd1;
         else if (sel >= 98) i_cnt = 16'd0;
         @(posedge i_clk);
         #1;
         expA = {mArmed, mFire, mIrq, mOvr, mErr, 8'(satCount(mEvents, 255))};
         expB = {mArmed, mFire, mIrq, mOvr, mErr, 2'(satCount(mEvents, 3))};
         nTotal++;
         if (outsA !== expA || outsB !== expB) begin
            if (shown < 10)
               $display("[TB] FAIL random_cycle_%0d: A got %b want %b, B got %b want %b",
                        cyc, outsA, expA, outsB, expB);
            shown++;
         end else nPass++;
      end
   endtask

   initial begin
      $display("[TB] starting cnt_match_timer bench");
      test_reset();
      test_one_shot();
      test_wrap();
      test_interrupt();
      test_reject_abort();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end

endmodule
